// File: rtl/imem_loader.sv
// Byte-stream program loader and instruction memory for a 16-bit CPU.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing checksum word after END_WORD.
module imem_loader #(
    parameter int unsigned DEPTH    = 1024,
    parameter logic [15:0] END_WORD = 16'hFFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic [15:0] fetch_addr,
    output logic [15:0] fetch_instr,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic        csum_error,
    output logic [10:0] word_count
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [10:0] DEPTH_W = 11'(DEPTH);

    localparam logic [2:0] ST_LOAD_HI = 3'd0;
    localparam logic [2:0] ST_LOAD_LO = 3'd1;
    localparam logic [2:0] ST_DONE    = 3'd2;
    localparam logic [2:0] ST_ERROR   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM_HI = 3'd4;
    localparam logic [2:0] ST_CSUM_LO = 3'd5;
`endif

    logic [2:0]  state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [10:0] word_count_q, word_count_d;
    logic [15:0] mem [DEPTH];
    logic        wr_en;
    logic        rx_fire;
    logic [15:0] rx_word;
    logic [9:0]  rd_index;
    logic        unused_fetch_bits;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;
    logic        csum_err_q, csum_err_d;
`endif

    always_comb begin
        rx_ready = 1'b0;
        case (state_q)
            ST_LOAD_HI, ST_LOAD_LO: rx_ready = ~reset;
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM_HI, ST_CSUM_LO: rx_ready = ~reset;
`endif
            default:                rx_ready = 1'b0;
        endcase
    end

    assign rx_fire = rx_valid & rx_ready;
    assign rx_word = {hi_q, rx_data};

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        word_count_d = word_count_q;
        wr_en        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
        csum_err_d   = csum_err_q;
`endif
        if (rx_fire) begin
            case (state_q)
                ST_LOAD_HI: begin
                    hi_d    = rx_data;
                    state_d = ST_LOAD_LO;
                end
                ST_LOAD_LO: begin
                    wr_en        = 1'b1;
                    word_count_d = word_count_q + 11'd1;
                    // END_WORD wins over overflow so a full-depth program still loads.
                    if (rx_word == END_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM_HI;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum_d = csum_q + rx_word;
`endif
                        state_d = (word_count_d == DEPTH_W) ? ST_ERROR : ST_LOAD_HI;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                ST_CSUM_HI: begin
                    hi_d    = rx_data;
                    state_d = ST_CSUM_LO;
                end
                ST_CSUM_LO: begin
                    if (rx_word == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_ERROR;
                        csum_err_d = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_LOAD_HI;
            hi_q         <= '0;
            word_count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= '0;
            csum_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            word_count_q <= word_count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
            csum_err_q   <= csum_err_d;
`endif
        end
    end

    // Memory is never cleared; stale words are hidden by the word_count mask on read.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[word_count_q[AW-1:0]] <= rx_word;
        end
    end

    assign rd_index          = fetch_addr[10:1];
    assign unused_fetch_bits = ^{fetch_addr[15:11], fetch_addr[0]};

    always_comb begin
        fetch_instr = 16'hFFFF;
        if ((state_q == ST_DONE) && ({1'b0, rd_index} < word_count_q)) begin
            fetch_instr = mem[rd_index[AW-1:0]];
        end
    end

    assign cpu_hold   = reset | (state_q != ST_DONE);
    assign load_done  = ~reset & (state_q == ST_DONE);
    assign load_error = ~reset & (state_q == ST_ERROR);
    assign word_count = word_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign csum_error = ~reset & csum_err_q;
`else
    assign csum_error = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized and directed bench for imem_loader; the reference model re-derives the
// load outcome from the full list of accepted bytes every cycle.
module tb_imem_loader;

    localparam int          DEPTH    = 1024;
    localparam logic [15:0] END_WORD = 16'hFFFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [15:0] fetch_addr;
    logic [15:0] fetch_instr;
    logic        cpu_hold;
    logic        load_done;
    logic        load_error;
    logic        csum_error;
    logic [10:0] word_count;

    always #5 clock = ~clock;

    imem_loader #(.DEPTH(DEPTH), .END_WORD(END_WORD)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .fetch_addr (fetch_addr),
        .fetch_instr(fetch_instr),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_error (load_error),
        .csum_error (csum_error),
        .word_count (word_count)
    );

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  acc[$];
    logic [15:0] exp_mem [DEPTH];
    int          st;     // 0 = still loading, 1 = done, 2 = error
    int          cnt;
    bit          cerr;

    // Outcome of the load implied by every byte accepted since the last reset.
    function automatic void eval_model();
        logic [15:0] sum;
        logic [15:0] w;
        bit          want_csum;
        sum = 16'h0000;
        want_csum = 1'b0;
        st = 0;
        cnt = 0;
        cerr = 1'b0;
        for (int i = 0; i + 1 < acc.size(); i += 2) begin
            w = {acc[i], acc[i+1]};
            if (want_csum) begin
                st   = (w == sum) ? 1 : 2;
                cerr = (w != sum);
                break;
            end
            exp_mem[cnt] = w;
            cnt++;
            if (w == END_WORD) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                want_csum = 1'b1;
`else
                st = 1;
                break;
`endif
            end else begin
                sum = sum + w;
                if (cnt == DEPTH) begin
                    st = 2;
                    break;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] rfa();
        logic [15:0] a;
        a = 16'($urandom_range(0, 80));
        a[15:11] = 5'($urandom);
        return a;
    endfunction

    task automatic cycle(input bit v, input logic [7:0] d, input bit r, input logic [15:0] fa);
        logic [9:0]  idx;
        logic [15:0] ef;
        @(negedge clock);
        reset = r;
        rx_valid = v;
        rx_data = d;
        fetch_addr = fa;
        #1;
        eval_model();
        idx = fa[10:1];
        ef = (st == 1 && int'(idx) < cnt) ? exp_mem[idx] : 16'hFFFF;
        check("rx_ready",    32'(rx_ready),    32'(!r && st == 0));
        check("cpu_hold",    32'(cpu_hold),    32'(r || st != 1));
        check("load_done",   32'(load_done),   32'(!r && st == 1));
        check("load_error",  32'(load_error),  32'(!r && st == 2));
        check("csum_error",  32'(csum_error),  32'(!r && cerr));
        check("word_count",  32'(word_count),  32'(cnt));
        check("fetch_instr", 32'(fetch_instr), 32'(ef));
        if (r) acc.delete();
        else if (v && st == 0) acc.push_back(d);
    endtask

    task automatic idle();
        cycle(1'b0, 8'($urandom), 1'b0, rfa());
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 8'($urandom), 1'b0, rfa());
    endtask

    task automatic do_reset();
        cycle(1'b0, 8'h00, 1'b1, rfa());
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) idle();
        cycle(1'b1, b, 1'b0, rfa());
    endtask

    task automatic send_word(input logic [15:0] w, input int maxgap);
        send_byte(w[15:8], $urandom_range(0, maxgap));
        send_byte(w[7:0],  $urandom_range(0, maxgap));
    endtask

    task automatic sweep();
        int lim;
        lim = 2 * cnt + 6;
        for (int a = 0; a < lim; a++) cycle(1'b0, 8'h00, 1'b0, 16'(a));
    endtask

    task automatic probe(input string tag, input logic [15:0] fa, input logic [15:0] expv);
        cycle(1'b0, 8'h00, 1'b0, fa);
        check(tag, 32'(fetch_instr), 32'(expv));
    endtask

    initial begin
        reset = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        fetch_addr = 16'h0000;
        repeat (2) @(posedge clock);
        do_reset();
        idle();

        // Basic program, back to back
        send_byte(8'h71, 0); send_byte(8'h0F, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(16'h710F, 0);
`endif
        idle();
        check("done_b2b",  32'(load_done),  32'd1);
        check("count_b2b", 32'(word_count), 32'd2);
        probe("f0_b2b", 16'h0000, 16'h710F);
        probe("f2_b2b", 16'h0002, 16'hFFFF);
        probe("f4_b2b", 16'h0004, 16'hFFFF);
        probe("f1_b2b", 16'hF801, 16'h710F);
        junk(4);

        // Same program, three idle cycles before each byte
        do_reset();
        send_byte(8'h71, 3); send_byte(8'h0F, 3); send_byte(8'hFF, 3); send_byte(8'hFF, 3);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h71, 3); send_byte(8'h0F, 3);
`endif
        idle();
        check("done_gap",  32'(load_done),  32'd1);
        check("count_gap", 32'(word_count), 32'd2);
        probe("f0_gap", 16'h0000, 16'h710F);
        probe("f4_gap", 16'h0004, 16'hFFFF);

        // Reset after a lone high byte discards it
        do_reset();
        send_byte(8'h71, 0);
        do_reset();
        send_byte(8'h72, 0); send_byte(8'h0F, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(16'h720F, 0);
`endif
        idle();
        probe("f0_rst", 16'h0000, 16'h720F);
        check("count_rst", 32'(word_count), 32'd2);

        // Random programs with random gaps
        for (int t = 0; t < 12; t++) begin
            logic [15:0] sum;
            logic [15:0] w;
            int n;
            int g;
            do_reset();
            sum = 16'h0000;
            n = $urandom_range(1, 30);
            g = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                w = 16'($urandom);
                if (w == END_WORD) w = 16'h1234;
                sum = sum + w;
                send_word(w, g);
            end
            send_word(END_WORD, g);
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_word((t % 3 == 0) ? sum + 16'd1 : sum, g);
`endif
            idle();
            sweep();
            junk(5);
        end

        // Overflow: DEPTH non-halt words
        do_reset();
        for (int k = 0; k < DEPTH; k++) send_word(16'h0000, 0);
        junk(6);
        check("err_ovf",   32'(load_error), 32'd1);
        check("count_ovf", 32'(word_count), 32'd1024);
        check("ready_ovf", 32'(rx_ready),   32'd0);

        // Halt word as the DEPTH-th word is a valid load
        do_reset();
        for (int k = 0; k < DEPTH - 1; k++) send_word(16'h0000, 0);
        send_word(END_WORD, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(16'h0000, 0);
`endif
        idle();
        check("done_full",  32'(load_done),  32'd1);
        check("count_full", 32'(word_count), 32'd1024);
        probe("flast_full", 16'd2046, 16'hFFFF);
        probe("fprev_full", 16'd2044, 16'h0000);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        send_word(16'h0001, 0); send_word(16'h0002, 0); send_word(16'hFFFF, 0); send_word(16'h0003, 0);
        idle();
        check("csum_ok_done",  32'(load_done),  32'd1);
        check("csum_ok_count", 32'(word_count), 32'd3);
        do_reset();
        send_word(16'h0001, 0); send_word(16'h0002, 0); send_word(16'hFFFF, 0); send_word(16'h0004, 0);
        idle();
        check("csum_bad_err",  32'(load_error), 32'd1);
        check("csum_bad_flag", 32'(csum_error), 32'd1);
        check("csum_bad_hold", 32'(cpu_hold),   32'd1);
`endif

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1024: program-memory depth in 16-bit words.
REQ-002 Parameter END_WORD, default 16'hFFFF: halt word that terminates a load.
REQ-003 Port clock  input  1: single clock; all state updates on rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port rx_valid  input  1: loader byte stream, byte offered.
REQ-006 Port rx_data  input  8: offered byte.
REQ-007 Port rx_ready  output  1: loader can accept a byte.
REQ-008 Port fetch_addr  input  16: CPU byte address (PC).
REQ-009 Port fetch_instr  output  16: instruction word at fetch_addr.
REQ-010 Port cpu_hold  output  1: CPU must not advance PC.
REQ-011 Port load_done  output  1: program loaded and valid.
REQ-012 Port load_error  output  1: load failed; sticky until reset.
REQ-013 Port csum_error  output  1: checksum mismatch (see Configuration).
REQ-014 Port word_count  output  11: words written in current load (0..DEPTH).

Function
REQ-015 The block SHALL implement states LOAD_HI, LOAD_LO, DONE, ERROR (plus CSUM_HI, CSUM_LO when configured).
REQ-016 A byte SHALL transfer only on a rising edge with rx_valid=1 and rx_ready=1; rx_valid without rx_ready SHALL have no effect.
REQ-017 rx_ready SHALL be 1 only in LOAD_HI, LOAD_LO, CSUM_HI, CSUM_LO and reset=0; 0 otherwise.
REQ-018 In LOAD_HI an accepted byte SHALL be held as word[15:8]; next state LOAD_LO.
REQ-019 In LOAD_LO an accepted byte SHALL complete word={hi,byte}, written to mem[word_count] on that same edge; word_count increments by 1.
REQ-020 If the completed word equals END_WORD it SHALL be stored, and the next state SHALL be DONE (or CSUM_HI when configured).
REQ-021 Else if word_count reaches DEPTH after the write, next state SHALL be ERROR (overflow); else LOAD_HI.
REQ-022 A DEPTH-th word equal to END_WORD SHALL be a valid load (DONE), not overflow.
REQ-023 Gaps (rx_valid=0) between or within words SHALL stall the FSM with no state change.
REQ-024 fetch_instr SHALL be combinational: index = fetch_addr[10:1]; fetch_addr[0] and [15:11] ignored.
REQ-025 fetch_instr SHALL be mem[index] only when state is DONE and index < word_count; otherwise 16'hFFFF.
REQ-026 cpu_hold SHALL be 1 in every state except DONE; load_done=1 only in DONE; load_error=1 only in ERROR.
REQ-027 DONE and ERROR SHALL be terminal until reset; bytes offered there are not accepted.

Reset
REQ-028 reset=1 SHALL, at the next rising edge, force state LOAD_HI, word_count=0, hi byte=0, checksum accumulator=0, and hold rx_ready=0, cpu_hold=1, load_done=0, load_error=0, csum_error=0 while asserted.
REQ-029 Reset mid-word SHALL discard any partial high byte; memory contents are not cleared but are masked by REQ-025.

Configuration
REQ-030 Macro IMEM_LOADER_CHECKSUM_EN defined: a 16-bit modulo-2^16 sum of all words preceding END_WORD SHALL be kept; after END_WORD, one more word (hi then lo, not stored, word_count unchanged) SHALL be received via CSUM_HI/CSUM_LO; match -> DONE, mismatch -> ERROR with csum_error=1.
REQ-031 Macro undefined: no checksum logic, END_WORD goes directly to DONE, csum_error tied 0.

Verification
REQ-032 Bytes 71,0F,FF,FF back-to-back after reset -> load_done=1 the edge after the 4th byte, word_count=2, fetch_addr 0 -> 710F, fetch_addr 2 -> FFFF, fetch_addr 4 -> FFFF.
REQ-033 Same bytes with rx_valid low 3 cycles between each -> identical final result; cpu_hold=1 and fetch_instr=FFFF at every cycle before DONE.
REQ-034 1024 words of 0000 -> load_error=1, word_count=1024, rx_ready=0; further bytes ignored.
REQ-035 Byte 71 then reset for 1 cycle, then 72,0F,FF,FF -> fetch_addr 0 -> 720F, word_count=2.
REQ-036 With IMEM_LOADER_CHECKSUM_EN: words 0001,0002,FFFF,0003 -> load_done=1, word_count=3; checksum word 0004 instead -> load_error=1, csum_error=1, cpu_hold=1.
